// File: rtl/action_arbiter.sv
// Action arbiter between the pet's buttons and its FSM: latches the requests, grants one
// legal action at a time, and runs the test-scenario selection and commit sequence.
module action_arbiter #(
    parameter int HOLD_CYC     = 4,
    parameter int LOCKOUT_CYC  = 1000,
    parameter int TEST_TIMEOUT = 50000,
    parameter int COMMIT_CYC   = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_sleep,
    input  logic       req_awake,
    input  logic       req_feed,
    input  logic       req_play,
    input  logic       req_test,
    input  logic [3:0] state,
    output logic       botonSleep,
    output logic       botonAwake,
    output logic       botonFeed,
    output logic       botonPlay,
    output logic       botonTest,
    output logic [3:0] BpulseTest,
    output logic       busy
);

    localparam int MAX_A   = (HOLD_CYC > LOCKOUT_CYC) ? HOLD_CYC : LOCKOUT_CYC;
    localparam int MAX_B   = (TEST_TIMEOUT > COMMIT_CYC) ? TEST_TIMEOUT : COMMIT_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] HOLD_END   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_END   = CNT_W'(LOCKOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_END     = CNT_W'(TEST_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] COMMIT_END = CNT_W'(COMMIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    localparam logic [3:0] ST_SLEEP = 4'd3;
    localparam logic [3:0] ST_DEATH = 4'd8;
    localparam logic [3:0] ST_TEST  = 4'd9;

    typedef enum logic [2:0] {
        ARB_IDLE,
        GRANT,
        LOCKOUT,
        TEST_SEL,
        TEST_COMMIT
    } arb_t;

    arb_t             r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_pend;   // bit order: {play, feed, awake, sleep}
    logic [3:0]       r_act;
    logic [3:0]       r_sel;
    logic             r_test;
    logic [3:0]       r_bpulse;

    logic [3:0]       w_req;
    logic [3:0]       w_legal;
    logic [3:0]       w_win;
    logic [3:0]       w_rest;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_req     = {req_play, req_feed, req_awake, req_sleep};
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // Legality filter and fixed priority awake > feed > sleep > play
    always_comb begin
        w_legal = r_pend;
        if (state == ST_DEATH || state == ST_TEST) begin
            w_legal = '0;
        end else if (state == ST_SLEEP) begin
            w_legal[0] = 1'b0;
            w_legal[3] = 1'b0;
        end else begin
            w_legal[1] = 1'b0;
        end
        w_win = '0;
        if (w_legal[1])      w_win = 4'b0010;
        else if (w_legal[2]) w_win = 4'b0100;
        else if (w_legal[0]) w_win = 4'b0001;
        else if (w_legal[3]) w_win = 4'b1000;
        w_rest = w_legal & ~w_win;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            r_cnt    <= '0;
            r_pend   <= '0;
            r_act    <= '0;
            r_sel    <= '0;
            r_test   <= 1'b0;
            r_bpulse <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (req_test) begin
                        r_state <= TEST_SEL;
                        r_test  <= 1'b1;
                        r_sel   <= '0;
                        r_cnt   <= '0;
                        r_pend  <= '0;
                    end else begin
                        r_pend <= w_rest | w_req;
                        if (|w_win) begin
                            r_state <= GRANT;
                            r_act   <= w_win;
                            r_cnt   <= '0;
                        end
                    end
                end
                GRANT: begin
                    r_pend <= r_pend | w_req;
                    if (r_cnt == HOLD_END) begin
                        r_state <= LOCKOUT;
                        r_act   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                LOCKOUT: begin
                    // The final lockout cycle doubles as the idle evaluation so a
                    // queued loser is granted back-to-back with the lockout end.
                    if (r_cnt == LOCK_END) begin
                        r_pend <= w_rest | w_req;
                        r_cnt  <= '0;
                        if (|w_win) begin
                            r_state <= GRANT;
                            r_act   <= w_win;
                        end else begin
                            r_state <= ARB_IDLE;
                        end
                    end else begin
                        r_pend <= r_pend | w_req;
                        r_cnt  <= w_cnt_inc;
                    end
                end
                TEST_SEL: begin
                    if (req_test) begin
                        r_sel <= (r_sel == 4'd9) ? 4'd1 : r_sel + 4'd1;
                        r_cnt <= '0;
                    end else if (r_cnt == TO_END) begin
                        r_test <= 1'b0;
                        r_cnt  <= '0;
                        if (r_sel != 4'd0) begin
                            r_state  <= TEST_COMMIT;
                            r_bpulse <= r_sel;
                        end else begin
                            r_state <= ARB_IDLE;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                TEST_COMMIT: begin
                    r_pend <= r_pend | w_req;
                    if (r_cnt == COMMIT_END) begin
                        r_state  <= LOCKOUT;
                        r_bpulse <= '0;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign botonSleep = r_act[0];
    assign botonAwake = r_act[1];
    assign botonFeed  = r_act[2];
    assign botonPlay  = r_act[3];
    assign botonTest  = r_test;
    assign BpulseTest = r_bpulse;
    assign busy       = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_action_arbiter.sv
// Directed bench for action_arbiter with short timing parameters; cycle numbers are
// counted from the first cycle after reset is released.
module tb_action_arbiter;

    logic       clk;
    logic       rst;
    logic       req_sleep, req_awake, req_feed, req_play, req_test;
    logic [3:0] state;
    logic       botonSleep, botonAwake, botonFeed, botonPlay, botonTest;
    logic [3:0] BpulseTest;
    logic       busy;

    int cyc;
    int n_pass;
    int n_total;

    action_arbiter #(
        .HOLD_CYC(2),
        .LOCKOUT_CYC(3),
        .TEST_TIMEOUT(5),
        .COMMIT_CYC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_sleep(req_sleep),
        .req_awake(req_awake),
        .req_feed(req_feed),
        .req_play(req_play),
        .req_test(req_test),
        .state(state),
        .botonSleep(botonSleep),
        .botonAwake(botonAwake),
        .botonFeed(botonFeed),
        .botonPlay(botonPlay),
        .botonTest(botonTest),
        .BpulseTest(BpulseTest),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    endtask

    // Advance one cycle; request inputs are single-cycle pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        req_sleep = 1'b0;
        req_awake = 1'b0;
        req_feed  = 1'b0;
        req_play  = 1'b0;
        req_test  = 1'b0;
    endtask

    task automatic go(input int n);
        while (cyc < n) tick();
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    function automatic logic [3:0] acts();
        return {botonPlay, botonFeed, botonAwake, botonSleep};
    endfunction

    initial begin
        n_pass = 0; n_total = 0; cyc = 0;
        rst = 1'b1; state = 4'd1;
        req_sleep = 0; req_awake = 0; req_feed = 0; req_play = 0; req_test = 0;

        // Reset state, with a coincident feed request that must be lost
        tick();
        req_feed = 1'b1;
        tick();
        rst = 1'b0;
        cyc = 0;
        chk("rst_outputs", {acts(), botonTest, BpulseTest, busy}, 32'd0);
        chk("rst_pend", dut.r_pend, 4'd0);
        go(4);
        chk("rst_lost_feed", {botonFeed, busy}, 2'b00);

        // Single feed
        state = 4'd1;
        reset_dut();
        go(10);
        req_feed = 1'b1;
        for (int c = 11; c <= 18; c++) begin
            go(c);
            chk("feed_out", botonFeed, (c >= 12 && c <= 13));
            chk("feed_busy", busy, (c >= 12 && c <= 16));
            chk("feed_others", {botonPlay, botonAwake, botonSleep}, 3'b000);
        end

        // Simultaneous awake + feed while sleeping
        state = 4'd3;
        reset_dut();
        go(10);
        req_awake = 1'b1;
        req_feed  = 1'b1;
        for (int c = 11; c <= 23; c++) begin
            go(c);
            chk("sim_awake", botonAwake, (c >= 12 && c <= 13));
            chk("sim_feed", botonFeed, (c >= 17 && c <= 18));
            chk("sim_busy", busy, (c >= 12 && c <= 21));
        end

        // Illegal play while dead
        state = 4'd8;
        reset_dut();
        go(10);
        req_play = 1'b1;
        for (int c = 11; c <= 18; c++) begin
            go(c);
            chk("dead_acts", acts(), 4'd0);
            if (c == 12) chk("dead_pend", dut.r_pend, 4'd0);
        end

        // Awake while not sleeping is illegal
        state = 4'd1;
        reset_dut();
        go(10);
        req_awake = 1'b1;
        for (int c = 11; c <= 18; c++) begin
            go(c);
            chk("awake_illegal", {acts(), busy}, 5'd0);
        end

        // Test selection of scenario 3
        state = 4'd1;
        reset_dut();
        go(10); req_test = 1'b1;
        go(14); req_test = 1'b1;
        go(16); req_test = 1'b1;
        go(18); req_test = 1'b1;
        for (int c = 11; c <= 32; c++) begin
            go(c);
            chk("tsel_test", botonTest, (c >= 11 && c <= 23));
            chk("tsel_bpulse", BpulseTest, (c >= 24 && c <= 27) ? 4'd3 : 4'd0);
            chk("tsel_busy", busy, (c >= 11 && c <= 30));
            if (c == 19) chk("tsel_sel", dut.r_sel, 4'd3);
        end

        // Abort with no selection press
        reset_dut();
        go(10); req_test = 1'b1;
        for (int c = 11; c <= 18; c++) begin
            go(c);
            chk("abort_test", botonTest, (c >= 11 && c <= 15));
            chk("abort_bpulse", BpulseTest, 4'd0);
            chk("abort_busy", busy, (c >= 11 && c <= 15));
        end

        // Ten presses wrap the selection back to 1
        reset_dut();
        go(10); req_test = 1'b1;
        for (int c = 11; c <= 20; c++) begin
            go(c);
            req_test = 1'b1;
        end
        go(25);
        chk("wrap_pre_test", botonTest, 1'b1);
        go(26);
        chk("wrap_bpulse", BpulseTest, 4'd1);
        chk("wrap_test", botonTest, 1'b0);

        // Reset during the second cycle of a sleep grant drops pending play
        state = 4'd1;
        reset_dut();
        go(10);
        req_sleep = 1'b1;
        req_play  = 1'b1;
        go(12);
        chk("rgrant_sleep1", botonSleep, 1'b1);
        go(13);
        chk("rgrant_sleep2", botonSleep, 1'b1);
        rst = 1'b1;
        go(14);
        rst = 1'b0;
        chk("rgrant_outs", {acts(), botonTest, BpulseTest, busy}, 32'd0);
        for (int c = 15; c <= 22; c++) begin
            go(c);
            chk("rgrant_noplay", {botonPlay, busy}, 2'b00);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
